elm_hidden_neuron: RTL and testbench
====================================

// Module: elm_hidden_neuron
// PURPOSE
// - Hidden-layer neuron datapath: consumes a serial input vector, reads one weight per element from its
//   weight memory (1-cycle read latency, ren/raddr/wout), multiply-accumulates, adds bias, activates.
// - Sits directly downstream of the per-neuron weight memory; output feeds the next layer's input bus.
// PARAMETERS
// - neuronNo       19  neuron index (label only, no functional effect)
// - layerNo        1   layer index (label only)
// - numWeight      784 elements per input vector (= weights read per vector), >=1, <=2**(addressWidth+1)
// - addressWidth   10  weight-memory address width; raddr is addressWidth+1 bits
// - dataWidth      16  signed fixed-point width of inputs, weights, bias, output
// - weightIntWidth 4   integer bits incl. sign (Q4.12 at defaults)
// PORTS
// - clk          in   1                   clock, rising edge
// - rst          in   1                   reset: one clock; reset is synchronous and active-high
// - myinput      in   dataWidth           signed input element
// - myinputValid in   1                   myinput valid this cycle
// - bias         in   dataWidth           signed bias, same Q format; sampled on the bias-add cycle
// - ren          out  1                   weight-memory read enable
// - raddr        out  addressWidth+1      weight-memory read address
// - wout         in   dataWidth           weight from memory, valid 1 cycle after ren
// - busy         out  1                   high from first accepted element until outvalid
// - out          out  dataWidth           activated neuron output
// - outvalid     out  1                   1-cycle pulse, out valid
// BEHAVIOUR
// - Reset values: ren=0, raddr=0, busy=0, out=0, outvalid=0; accumulator, pipeline, state cleared.
// - FSM: IDLE -> RUN on first accepted element; RUN -> DRAIN after element numWeight-1 accepted;
//   DRAIN -> IDLE when result written (outvalid pulse).
// - Accept: myinputValid high in IDLE/RUN; ren=myinputValid combinationally, raddr = element count.
//   Count increments per accepted element; returns to 0 after the last. Gaps in valid are allowed.
// - myinputValid in DRAIN is ignored (dropped, ren=0, no count change).
// - Pipeline (last element accepted at cycle T): T+1 weight arrives, input delayed 1 cycle to align;
//   product (2*dataWidth, signed) registered at T+2; accumulator updated at T+3; out/outvalid at T+4.
// - Accumulator 2*dataWidth signed, saturating: on overflow clamps to max/min and stays clamped.
// - Bias add: acc + (sign-extended bias << (dataWidth-weightIntWidth)), saturating, at T+3 -> T+4.
// - Output slice bits [2*dataWidth-1-weightIntWidth -: dataWidth]; if discarded upper bits are not a
//   sign extension, saturate to 0x7FFF / 0x8000 (defaults).
// - Accumulator cleared the cycle after outvalid; next vector may start the cycle outvalid is high
//   only if IDLE reached, i.e. first element of next vector accepted at earliest T+5.
// - out holds its value until the next outvalid; outvalid never asserts twice per vector.
// - rst mid-vector: abandon all in-flight state, no outvalid, next accepted element is element 0.
// CONFIGURATION
// - RELU_EN defined: out = max(0, saturated result); negative results give 0.
// - RELU_EN undefined: linear; out = saturated result, negative values passed through.
// TESTING (defaults, numWeight=4 unless noted; weight memory model with 1-cycle latency)
// - 4 x input 0x1000, weights 0x1000, bias 0 -> out=0x4000, outvalid exactly 4 cycles after last valid.
// - Same, bias 0x0800 -> out=0x4800; raddr sequence 0,1,2,3 then 0 for next vector.
// - 4 x input 0x7FFF, weights 0x7FFF -> accumulator saturates, out=0x7FFF.
// - 4 x input 0x1000, weights 0xF000, bias 0 -> out=0xC000 (no RELU_EN) / 0x0000 (RELU_EN).
// - Valid with 2-cycle gaps between elements -> same result as back-to-back; valid during DRAIN ignored.
// - rst after 2 elements, then full vector of 0x1000/0x1000 -> single outvalid, out=0x4000.

Source files
------------

// File: rtl/elm_hidden_neuron.sv
// ---------------------------------------------------------------------------
// elm_hidden_neuron
// Hidden-layer neuron datapath. It takes a serial input vector and reads one
// weight per element from a 1-cycle-latency weight memory. It then does a
// saturating multiply-accumulate, adds the bias and drives the activated
// result for one cycle with outvalid.
//
// Optional feature macro: RELU_EN
//   defined   -> out = max(0, saturated result)
//   undefined -> linear output, negative results passed through
// ---------------------------------------------------------------------------
module elm_hidden_neuron #(
    parameter int neuronNo       = 19,
    parameter int layerNo        = 1,
    parameter int numWeight      = 784,
    parameter int addressWidth   = 10,
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [dataWidth-1:0] myinput,
    input  logic                        myinputValid,
    input  logic signed [dataWidth-1:0] bias,
    output logic                        ren,
    output logic [addressWidth:0]       raddr,
    input  logic signed [dataWidth-1:0] wout,
    output logic                        busy,
    output logic signed [dataWidth-1:0] out,
    output logic                        outvalid
);

    localparam int ACC_W = 2 * dataWidth;
    localparam int FRAC  = dataWidth - weightIntWidth;

    localparam logic [addressWidth:0] LAST_IDX = (addressWidth + 1)'(numWeight - 1);
    localparam logic [addressWidth:0] CNT_ONE  = (addressWidth + 1)'(1);

    localparam logic [ACC_W-1:0]     ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0]     ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam logic [dataWidth-1:0] OUT_MAX = {1'b0, {(dataWidth - 1){1'b1}}};
    localparam logic [dataWidth-1:0] OUT_MIN = {1'b1, {(dataWidth - 1){1'b0}}};

    // Labels carry no function; they are only sanity-checked with the sizing.
    if (numWeight < 1 || numWeight > 2 ** (addressWidth + 1) || neuronNo < 0 || layerNo < 0)
    begin : g_param_check
        $error("elm_hidden_neuron: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Signed add with clamping; the MSB of the result flags an overflow.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        end else begin
            sat_add = {1'b0, s[ACC_W-1:0]};
        end
    endfunction

    state_t                     state_q, state_d;
    logic [addressWidth:0]      count_q, count_d;

    // Stage 1: input delayed to line up with the weight returned by memory.
    logic signed [dataWidth-1:0] x_q;
    logic                        v1_q, l1_q;
    // Stage 2: registered product.
    logic signed [ACC_W-1:0]     prod_q;
    logic                        v2_q, l2_q;
    // Stage 3: accumulator, sticky once it has clamped.
    logic signed [ACC_W-1:0]     acc_q;
    logic                        acc_sat_q;
    logic                        l3_q;
    // Stage 4: activated output.
    logic signed [dataWidth-1:0] out_q;
    logic                        outvalid_q;

    logic                        accept;
    logic                        last_elem;
    logic signed [ACC_W-1:0]     prod_full;
    logic [ACC_W:0]              acc_sum;
    logic [ACC_W-1:0]            bias_ext;
    logic [ACC_W:0]              bias_sum;
    logic signed [ACC_W-1:0]     biased;
    logic signed [ACC_W-1:0]     shifted;
    logic [ACC_W-dataWidth:0]    upper;
    logic [dataWidth-1:0]        sat_res;
    logic [dataWidth-1:0]        final_out;

    // Elements are taken whenever valid arrives outside DRAIN.
    assign accept    = myinputValid && (state_q != DRAIN);
    assign last_elem = accept && (count_q == LAST_IDX);

    assign ren      = accept;
    assign raddr    = count_q;
    assign busy     = (state_q != IDLE);
    assign out      = out_q;
    assign outvalid = outvalid_q;

    // State and element-count register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: count elements, move to DRAIN after the last one,
    // and go back to IDLE once the result has been presented.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    if (last_elem) begin
                        count_d = '0;
                        state_d = DRAIN;
                    end else begin
                        count_d = count_q + CNT_ONE;
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                if (outvalid_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Arithmetic: product, accumulate, bias add, output slice and activation.
    always_comb begin
        prod_full = $signed({{(ACC_W - dataWidth){x_q[dataWidth-1]}}, x_q}) *
                    $signed({{(ACC_W - dataWidth){wout[dataWidth-1]}}, wout});
        acc_sum   = sat_add(acc_q, prod_q);
        bias_ext  = {{(ACC_W - dataWidth){bias[dataWidth-1]}}, bias} << FRAC;
        bias_sum  = sat_add(acc_q, bias_ext);
        biased    = $signed(bias_sum[ACC_W-1:0]);
        shifted   = biased >>> FRAC;
        upper     = shifted[ACC_W-1:dataWidth-1];
        // The slice is only exact when the discarded upper bits are pure sign copies.
        if (bias_sum[ACC_W] || !((&upper) || (~|upper))) begin
            sat_res = biased[ACC_W-1] ? OUT_MIN : OUT_MAX;
        end else begin
            sat_res = shifted[dataWidth-1:0];
        end
`ifdef RELU_EN
        final_out = sat_res[dataWidth-1] ? '0 : sat_res;
`else
        final_out = sat_res;
`endif
    end

    // Datapath pipeline; a reset throws away all in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            v1_q       <= 1'b0;
            l1_q       <= 1'b0;
            prod_q     <= '0;
            v2_q       <= 1'b0;
            l2_q       <= 1'b0;
            acc_q      <= '0;
            acc_sat_q  <= 1'b0;
            l3_q       <= 1'b0;
            out_q      <= '0;
            outvalid_q <= 1'b0;
        end else begin
            v1_q <= accept;
            l1_q <= last_elem;
            if (accept) begin
                x_q <= myinput;
            end

            v2_q <= v1_q;
            l2_q <= l1_q;
            if (v1_q) begin
                prod_q <= prod_full;
            end

            l3_q <= l2_q;
            if (outvalid_q) begin
                acc_q     <= '0;
                acc_sat_q <= 1'b0;
            end else if (v2_q && !acc_sat_q) begin
                acc_q     <= $signed(acc_sum[ACC_W-1:0]);
                acc_sat_q <= acc_sum[ACC_W];
            end

            outvalid_q <= l3_q;
            if (l3_q) begin
                out_q <= final_out;
            end
        end
    end

endmodule

// File: tb/tb_elm_hidden_neuron.sv
// ---------------------------------------------------------------------------
// tb_elm_hidden_neuron
// Directed self-checking bench for elm_hidden_neuron with numWeight=4 and a
// 1-cycle-latency weight memory model. Inputs change and outputs are sampled
// around the falling edge.
// ---------------------------------------------------------------------------
module tb_elm_hidden_neuron;

    localparam int NW = 4;

    logic        clk;
    logic        rst;
    logic [15:0] myinput;
    logic        myinputValid;
    logic [15:0] bias;
    logic        ren;
    logic [10:0] raddr;
    logic [15:0] wout = '0;
    logic        busy;
    logic [15:0] out;
    logic        outvalid;

    logic [15:0] wmem [NW];
    logic [15:0] xv   [NW];

    int total = 0;
    int bad   = 0;

    elm_hidden_neuron #(
        .numWeight(NW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .myinput     (myinput),
        .myinputValid(myinputValid),
        .bias        (bias),
        .ren         (ren),
        .raddr       (raddr),
        .wout        (wout),
        .busy        (busy),
        .out         (out),
        .outvalid    (outvalid)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memory model, one cycle of read latency.
    always @(posedge clk) begin
        if (ren) wout <= wmem[raddr[1:0]];
    end

    // Absolute safety net; all waits below are bounded anyway.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [15:0] x0, input logic [15:0] x1,
                        input logic [15:0] x2, input logic [15:0] x3,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3);
        xv[0] = x0; xv[1] = x1; xv[2] = x2; xv[3] = x3;
        wmem[0] = w0; wmem[1] = w1; wmem[2] = w2; wmem[3] = w3;
    endtask

    // Drives one vector starting at the current (post-negedge) time and
    // watches the result window up to T+5. Returns at T+5 with valid low.
    task automatic run_vector(input string name, input logic [15:0] bias_v,
                              input int gap, input bit junk,
                              input logic [15:0] exp_out);
        int first_lat;
        int pulses;
        first_lat = 0;
        pulses    = 0;
        bias      = bias_v;
        for (int i = 0; i < NW; i++) begin
            myinput      = xv[i];
            myinputValid = 1'b1;
            #1;
            total++;
            if (ren !== 1'b1) begin
                bad++; $display("FAIL %s ren[%0d]: got %b expected 1", name, i, ren);
            end
            total++;
            if (raddr !== 11'(i)) begin
                bad++; $display("FAIL %s raddr[%0d]: got %0d expected %0d", name, i, raddr, i);
            end
            if (i > 0) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL %s busy[%0d]: got %b expected 1", name, i, busy);
                end
            end
            @(negedge clk);
            if (i < NW - 1) begin
                for (int g = 0; g < gap; g++) begin
                    myinputValid = 1'b0;
                    #1;
                    total++;
                    if (ren !== 1'b0) begin
                        bad++; $display("FAIL %s ren_gap: got %b expected 0", name, ren);
                    end
                    @(negedge clk);
                end
            end
        end
        for (int lat = 1; lat <= 5; lat++) begin
            myinputValid = junk && (lat <= 4);
            myinput      = 16'h7FFF;
            #1;
            if (junk && lat <= 4) begin
                total++;
                if (ren !== 1'b0) begin
                    bad++; $display("FAIL %s ren_drain[%0d]: got %b expected 0", name, lat, ren);
                end
            end
            if (outvalid === 1'b1) begin
                pulses++;
                if (first_lat == 0) first_lat = lat;
            end
            if (lat == 4) begin
                total++;
                if (out !== exp_out) begin
                    bad++; $display("FAIL %s out: got %h expected %h", name, out, exp_out);
                end
            end
            if (lat == 5) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL %s busy_end: got %b expected 0", name, busy);
                end
                total++;
                if (raddr !== 11'd0) begin
                    bad++; $display("FAIL %s raddr_end: got %0d expected 0", name, raddr);
                end
                total++;
                if (out !== exp_out) begin
                    bad++; $display("FAIL %s out_hold: got %h expected %h", name, out, exp_out);
                end
            end
            if (lat < 5) @(negedge clk);
        end
        myinputValid = 1'b0;
        total++;
        if (first_lat !== 4) begin
            bad++; $display("FAIL %s latency: got %0d expected 4", name, first_lat);
        end
        total++;
        if (pulses !== 1) begin
            bad++; $display("FAIL %s pulses: got %0d expected 1", name, pulses);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        myinputValid = 1'b0;
        myinput = '0;
        bias = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (ren !== 1'b0) begin bad++; $display("FAIL reset ren: got %b expected 0", ren); end
        total++;
        if (raddr !== 11'd0) begin bad++; $display("FAIL reset raddr: got %0d expected 0", raddr); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL reset out: got %h expected 0000", out); end
        total++;
        if (outvalid !== 1'b0) begin bad++; $display("FAIL reset outvalid: got %b expected 0", outvalid); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load(16'h1000, 16'h1000, 16'h1000, 16'h1000,
             16'h1000, 16'h1000, 16'h1000, 16'h1000);
        run_vector("basic", 16'h0000, 0, 1'b0, 16'h4000);
    endtask

    // Starts at T+5 of the previous vector, so it is also the back-to-back case.
    task automatic test_back_to_back_bias();
        load(16'h1000, 16'h1000, 16'h1000, 16'h1000,
             16'h1000, 16'h1000, 16'h1000, 16'h1000);
        run_vector("bias", 16'h0800, 0, 1'b0, 16'h4800);
    endtask

    task automatic test_mixed();
        // 1.0*1.0 + 2.0*1.0 + (-1.0)*1.0 + 0.5*2.0 = 3.0
        load(16'h1000, 16'h2000, 16'hF000, 16'h0800,
             16'h1000, 16'h1000, 16'h1000, 16'h2000);
        run_vector("mixed", 16'h0000, 0, 1'b0, 16'h3000);
    endtask

    task automatic test_acc_saturate();
        load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
             16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_vector("acc_sat", 16'h0000, 0, 1'b0, 16'h7FFF);
    endtask

    task automatic test_out_clamp();
        // 4 * 7.0 = 28.0 and 4 * -7.0 = -28.0 exceed the Q4.12 output range.
        load(16'h7000, 16'h7000, 16'h7000, 16'h7000,
             16'h1000, 16'h1000, 16'h1000, 16'h1000);
        run_vector("clamp_pos", 16'h0000, 0, 1'b0, 16'h7FFF);
        load(16'h9000, 16'h9000, 16'h9000, 16'h9000,
             16'h1000, 16'h1000, 16'h1000, 16'h1000);
`ifdef RELU_EN
        run_vector("clamp_neg", 16'h0000, 0, 1'b0, 16'h0000);
`else
        run_vector("clamp_neg", 16'h0000, 0, 1'b0, 16'h8000);
`endif
    endtask

    task automatic test_negative();
        load(16'h1000, 16'h1000, 16'h1000, 16'h1000,
             16'hF000, 16'hF000, 16'hF000, 16'hF000);
`ifdef RELU_EN
        run_vector("negative", 16'h0000, 0, 1'b0, 16'h0000);
`else
        run_vector("negative", 16'h0000, 0, 1'b0, 16'hC000);
`endif
    endtask

    task automatic test_gaps_drain();
        load(16'h1000, 16'h1000, 16'h1000, 16'h1000,
             16'h1000, 16'h1000, 16'h1000, 16'h1000);
        run_vector("gaps", 16'h0000, 2, 1'b1, 16'h4000);
    endtask

    task automatic test_reset_mid();
        int spurious;
        spurious = 0;
        load(16'h1000, 16'h1000, 16'h1000, 16'h1000,
             16'h1000, 16'h1000, 16'h1000, 16'h1000);
        bias = 16'h0000;
        @(negedge clk);
        myinput = xv[0]; myinputValid = 1'b1;
        @(negedge clk);
        myinput = xv[1];
        @(negedge clk);
        myinputValid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy: got %b expected 0", busy); end
        total++;
        if (raddr !== 11'd0) begin bad++; $display("FAIL rst_mid raddr: got %0d expected 0", raddr); end
        for (int c = 0; c < 6; c++) begin
            if (outvalid === 1'b1) spurious++;
            @(negedge clk);
        end
        total++;
        if (spurious !== 0) begin
            bad++; $display("FAIL rst_mid spurious_outvalid: got %0d expected 0", spurious);
        end
        run_vector("rst_mid", 16'h0000, 0, 1'b0, 16'h4000);
    endtask

    initial begin
        rst = 1'b1;
        myinputValid = 1'b0;
        myinput = '0;
        bias = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back_bias();
        test_mixed();
        test_acc_saturate();
        test_out_clamp();
        test_negative();
        test_gaps_drain();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
